stream_tx_source: RTL
=====================

Name: stream_tx_source

Overview:
- Transmit-side counterpart of the design's byte-stream receiver.
- Buffers bytes loaded by a testbench or upstream logic in a small FIFO.
- Emits them as bursts on a valid/ready stream toward a receiver that drives ready.
- Burst length is programmed per start request; a one-cycle done pulse marks burst completion.

Parameters:
- DATA_WIDTH, 8, stream and load data width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  load strobe; pushes wr_data when not full.
- wr_data  input  DATA_WIDTH  load data.
- wr_full  output  1  FIFO full.
- wr_overflow  output  1  sticky; set by wr_en while full.
- start  input  1  begin burst; sampled only in IDLE.
- burst_len  input  8  number of beats; sampled with start.
- stream_out_valid  output  1  beat available.
- stream_out_data  output  DATA_WIDTH  beat data, FIFO head.
- stream_out_ready  input  1  receiver accepts.
- busy  output  1  high in SEND.
- done  output  1  one-cycle pulse at burst end.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; pointers 0; fifo_level=0.
  - wr_full=0, wr_overflow=0, stream_out_valid=0, stream_out_data=0.
  - busy=0, done=0, remaining=0, state IDLE.
  - Reset mid-burst discards FIFO contents and the burst; no done pulse.
- FIFO:
  - Push on wr_en && !wr_full.
  - Pop on stream_out_valid && stream_out_ready.
  - wr_full and fifo_level are registered state. A push attempted while full is rejected even if a pop occurs in the same cycle; it sets wr_overflow.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed byte is visible on stream_out_data no earlier than the next cycle.
- FSM states: IDLE, SEND, FINISH.
  - IDLE: stream_out_valid=0 regardless of FIFO level. If start=1 and burst_len=0, go to FINISH. If start=1 and burst_len>0, latch remaining=burst_len and go to SEND.
  - SEND: stream_out_valid = FIFO not empty. stream_out_data = FIFO head.
    - On a handshake: pop, remaining decrements.
    - On the handshake where remaining=1: go to FINISH.
    - start is ignored in SEND.
    - FIFO empty: valid=0, wait; no timeout.
  - FINISH: done=1 for exactly one cycle, then IDLE. A start in FINISH is ignored.
- Handshake rules:
  - Once stream_out_valid=1, valid and data hold stable until the handshake.
  - Valid never depends combinationally on stream_out_ready.
  - At most one beat per cycle; back-to-back beats allowed at full throughput.
- Latency:
  - start, with FIFO already non-empty, to first valid: 1 cycle.
  - Last handshake to done: 1 cycle.
- busy=1 only in SEND. wr_overflow clears only on reset.

Test Plan:
- Load 0x11,0x22,0x33; start with burst_len=3 and ready held 1 → valid for 3 consecutive cycles with data 0x11,0x22,0x33; done pulses once the cycle after 0x33; fifo_level=0.
- Load 4 bytes into DEPTH=4, then one more write of 0xEE → wr_full=1, wr_overflow=1, fifo_level=4; 0xEE is never emitted.
- Burst of 2 with ready toggling 0,1,0,0,1 → valid/data held stable across stalls; exactly 2 handshakes; done after the second.
- start with burst_len=2 on an empty FIFO; push 0xA5 three cycles later → valid rises the cycle after the push; second beat waits for the next push; busy stays 1 throughout.
- start with burst_len=0 → done the next cycle, no valid, FIFO untouched; a start during SEND is ignored.
- Deassert reset_n mid-burst, after 1 of 3 beats → all outputs return to reset values immediately; after release, valid stays 0 until a new start.

Source files
------------

// File: rtl/stream_tx_source.sv
// Burst transmitter: a small load FIFO drained onto a valid/ready stream.
// Each start request sends burst_len beats, then pulses done for one cycle.
module stream_tx_source #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_full,
  output logic                       wr_overflow,
  input  logic                       start,
  input  logic [7:0]                 burst_len,
  output logic                       stream_out_valid,
  output logic [DATA_WIDTH-1:0]      stream_out_data,
  input  logic                       stream_out_ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_nxt;
  logic [7:0]            remaining, remaining_nxt;
  logic                  push, pop, fifo_empty;

  assign fifo_empty = (fifo_level == '0);
  // Full is the registered flag, so a push while full is refused even if a pop frees a slot.
  assign push       = wr_en && !wr_full;
  assign pop        = stream_out_valid && stream_out_ready;

  assign stream_out_data = stream_out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    level_nxt = fifo_level;
    case ({push, pop})
      2'b10:   level_nxt = fifo_level + LW'(1);
      2'b01:   level_nxt = fifo_level - LW'(1);
      default: level_nxt = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      wr_full     <= 1'b0;
      wr_overflow <= 1'b0;
      state       <= IDLE;
      remaining   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level  <= level_nxt;
      wr_full     <= (level_nxt == LW'(DEPTH));
      wr_overflow <= wr_overflow | (wr_en & wr_full);
      state       <= state_nxt;
      remaining   <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    remaining_nxt    = remaining;
    stream_out_valid = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (burst_len == 8'd0) begin
            state_nxt = FINISH;
          end else begin
            remaining_nxt = burst_len;
            state_nxt     = SEND;
          end
        end
      end
      SEND: begin
        busy             = 1'b1;
        stream_out_valid = !fifo_empty;
        // Handshake term is rebuilt from fifo_empty to keep valid free of any loop through pop.
        if (stream_out_ready && !fifo_empty) begin
          remaining_nxt = remaining - 8'd1;
          if (remaining == 8'd1) state_nxt = FINISH;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
